div_acc: RTL and testbench



---
 rtl/div_acc.sv | 121 ++++++++++++
 tb/tb_div_acc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_acc.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per clock,
// results held in output registers and flagged with a one-cycle Done pulse.
module div_acc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Divident,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Done,
    output logic             Busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   r;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             last;

    // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow
    always_comb begin
        shifted = {r[WIDTH-1:0], q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        r_next  = shifted;
        q_next  = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_next = trial;
            q_next = {q[WIDTH-2:0], 1'b1};
        end
        last = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are pure state decodes, so no input reaches them combinationally
    always_comb begin
        Done = 1'b0;
        Busy = 1'b0;
        case (state)
            RUN:     Busy = 1'b1;
            DONE:    begin
                Done = 1'b1;
                Busy = 1'b1;
            end
            default: begin
                Done = 1'b0;
                Busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q         <= '0;
            d         <= '0;
            r         <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        q   <= Divident;
                        d   <= Divisor;
                        r   <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    q   <= q_next;
                    r   <= r_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        Quotient  <= q_next;
                        Remainder <= r_next[WIDTH-1:0];
                    end
                end
                default: begin
                    q <= q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_acc.sv
// Directed self-checking bench for div_acc: latency, results, start filtering and reset.
module tb_div_acc;

    localparam int unsigned WIDTH = 16;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [WIDTH-1:0] Divident;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Done;
    logic             Busy;

    int n_cmp;
    int n_err;

    div_acc #(.WIDTH(WIDTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Divident  (Divident),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Done      (Done),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called in cycle 0 of a divide; leaves the bench in cycle 18 (IDLE)
    task automatic run_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
        Divident = a;
        Divisor  = b;
        Start    = 1'b1;
        chk({tag, " busy c0"}, 32'(Busy), 32'd0);
        step();
        Start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk($sformatf("%s done c%0d", tag, c), 32'(Done), (c == 17) ? 32'd1 : 32'd0);
            chk($sformatf("%s busy c%0d", tag, c), 32'(Busy), (c <= 17) ? 32'd1 : 32'd0);
            if (c == 17) begin
                chk({tag, " quotient"}, 32'(Quotient), 32'(eq));
                chk({tag, " remainder"}, 32'(Remainder), 32'(er));
            end
            if (c < 18) step();
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        Reset    = 1'b1;
        Start    = 1'b0;
        Divident = '0;
        Divisor  = '0;
        step();
        step();
        chk("reset done", 32'(Done), 32'd0);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset quotient", 32'(Quotient), 32'd0);
        chk("reset remainder", 32'(Remainder), 32'd0);
        Reset = 1'b0;
        step();

        run_div("basic", 16'd20000, 16'd10, 16'd2000, 16'd0);
        run_div("max_by_7", 16'd65535, 16'd7, 16'd9362, 16'd1);
        run_div("small", 16'd5, 16'd9, 16'd0, 16'd5);
        run_div("max_by_1", 16'd65535, 16'd1, 16'd65535, 16'd0);
        run_div("zero_num", 16'd0, 16'd3, 16'd0, 16'd0);
        run_div("div_zero", 16'd1234, 16'd0, 16'hFFFF, 16'd1234);

        // Start pulses in RUN and DONE and operand changes must be ignored
        Divident = 16'd100;
        Divisor  = 16'd3;
        Start    = 1'b1;
        step();
        Start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) begin
                Divident = 16'd50;
                Divisor  = 16'd5;
            end
            chk($sformatf("busyst done c%0d", c), 32'(Done), (c == 17) ? 32'd1 : 32'd0);
            chk($sformatf("busyst busy c%0d", c), 32'(Busy), (c <= 17) ? 32'd1 : 32'd0);
            if (c == 17) begin
                chk("busyst quotient", 32'(Quotient), 32'd33);
                chk("busyst remainder", 32'(Remainder), 32'd1);
            end
            Start = (c == 5 || c == 17) ? 1'b1 : 1'b0;
            step();
        end
        Start = 1'b0;

        // Start held high: second divide accepted in the first IDLE cycle after DONE
        Divident = 16'd20000;
        Divisor  = 16'd10;
        Start    = 1'b1;
        step();
        for (int c = 1; c <= 36; c++) begin
            if (c == 18) begin
                Divident = 16'd7;
                Divisor  = 16'd2;
            end
            chk($sformatf("b2b done c%0d", c), 32'(Done), (c == 17 || c == 35) ? 32'd1 : 32'd0);
            chk($sformatf("b2b busy c%0d", c), 32'(Busy), (c == 18 || c == 36) ? 32'd0 : 32'd1);
            if (c >= 17 && c <= 34) begin
                chk($sformatf("b2b hold q c%0d", c), 32'(Quotient), 32'd2000);
                chk($sformatf("b2b hold r c%0d", c), 32'(Remainder), 32'd0);
            end
            if (c == 35) begin
                chk("b2b second quotient", 32'(Quotient), 32'd3);
                chk("b2b second remainder", 32'(Remainder), 32'd1);
                Start = 1'b0;
            end
            if (c < 36) step();
        end

        // Reset in cycle 8 of a divide discards it and clears results
        Divident = 16'd20000;
        Divisor  = 16'd10;
        Start    = 1'b1;
        step();
        Start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("rst busy c%0d", c), 32'(Busy), 32'd1);
            if (c < 8) step();
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst after busy", 32'(Busy), 32'd0);
        chk("rst after done", 32'(Done), 32'd0);
        chk("rst after quotient", 32'(Quotient), 32'd0);
        chk("rst after remainder", 32'(Remainder), 32'd0);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("rst no done +%0d", c), 32'(Done), 32'd0);
            if (c == 0) step();
            else break;
        end
        run_div("after_rst", 16'd9, 16'd4, 16'd2, 16'd1);

        // Reset wins over Start
        Divident = 16'd20000;
        Divisor  = 16'd10;
        Reset    = 1'b1;
        Start    = 1'b1;
        step();
        Reset = 1'b0;
        Start = 1'b0;
        chk("rst_start busy", 32'(Busy), 32'd0);
        chk("rst_start quotient", 32'(Quotient), 32'd0);
        step();
        chk("rst_start idle busy", 32'(Busy), 32'd0);
        chk("rst_start idle done", 32'(Done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
